// File: rtl/bsg_credit_rr_sched.sv
// rtl/bsg_credit_rr_sched.sv - credit-gated round-robin scheduler with packet lock
// Grants one beat per cycle to a requester while credits are available; multi-beat packets hold the channel.
module bsg_credit_rr_sched #(
  parameter int num_req_p          = 4,
  parameter int init_wait_cycles_p = 4,
  parameter int lg_req_lp          = $clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] req_i,
  input  logic [num_req_p-1:0] last_i,
  input  logic                 credits_avail_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [lg_req_lp-1:0] tag_o,
  output logic                 valid_o,
  output logic                 dec_credit_o,
  output logic                 ready_o,
  output logic                 locked_o,
  output logic                 starve_o
);

  localparam int cnt_w_lp = (init_wait_cycles_p > 1) ? $clog2(init_wait_cycles_p) : 1;
  localparam int sum_w_lp = lg_req_lp + 1;

  typedef enum logic [1:0] {
    e_init = 2'd0,
    e_idle = 2'd1,
    e_lock = 2'd2
  } state_e;

  state_e               state_r, state_n;
  logic [cnt_w_lp-1:0]  cnt_r, cnt_n;
  logic [lg_req_lp-1:0] ptr_r, ptr_n;
  logic [lg_req_lp-1:0] owner_r, owner_n;
  logic [lg_req_lp-1:0] tag_r, tag_n;

  logic                 scan_found;
  logic [lg_req_lp-1:0] scan_idx;
  logic [sum_w_lp-1:0]  cand;
  logic                 gnt_v;
  logic [lg_req_lp-1:0] gnt_idx;
  logic                 eligible;

  function automatic logic [lg_req_lp-1:0] wrap_inc(input logic [lg_req_lp-1:0] i);
    return (i == lg_req_lp'(num_req_p - 1)) ? '0 : i + 1'b1;
  endfunction

  // Cyclic priority scan starting at ptr_r; cand wraps explicitly so non-power-of-two counts work.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = {1'b0, ptr_r} + sum_w_lp'(i);
      if (cand >= sum_w_lp'(num_req_p)) begin
        cand = cand - sum_w_lp'(num_req_p);
      end
      if (!scan_found && req_i[cand[lg_req_lp-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = cand[lg_req_lp-1:0];
      end
    end
  end

  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    ptr_n    = ptr_r;
    owner_n  = owner_r;
    gnt_v    = 1'b0;
    gnt_idx  = tag_r;
    eligible = 1'b0;

    case (state_r)
      e_init: begin
        cnt_n = cnt_r + 1'b1;
        if (cnt_r == cnt_w_lp'(init_wait_cycles_p - 1)) begin
          state_n = e_idle;
        end
      end
      e_idle: begin
        eligible = |req_i;
        if (credits_avail_i && scan_found) begin
          gnt_v   = 1'b1;
          gnt_idx = scan_idx;
          if (last_i[scan_idx]) begin
            ptr_n = wrap_inc(scan_idx);
          end else begin
            state_n = e_lock;
            owner_n = scan_idx;
          end
        end
      end
      e_lock: begin
        // Only the owner may move; a dropped owner request simply stalls the channel.
        eligible = req_i[owner_r];
        if (req_i[owner_r] && credits_avail_i) begin
          gnt_v   = 1'b1;
          gnt_idx = owner_r;
          if (last_i[owner_r]) begin
            state_n = e_idle;
            ptr_n   = wrap_inc(owner_r);
          end
        end
      end
      default: begin
        state_n = e_init;
      end
    endcase

    tag_n = gnt_v ? gnt_idx : tag_r;

    grant_o          = '0;
    grant_o[gnt_idx] = gnt_v;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_init;
      cnt_r   <= '0;
      ptr_r   <= '0;
      owner_r <= '0;
      tag_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      tag_r   <= tag_n;
    end
  end

  assign tag_o        = gnt_idx;
  assign valid_o      = gnt_v;
  assign dec_credit_o = gnt_v;
  assign ready_o      = (state_r != e_init);
  assign locked_o     = (state_r == e_lock);
  assign starve_o     = ready_o && eligible && !credits_avail_i;

endmodule

// File: tb/tb_bsg_credit_rr_sched.sv
// tb/tb_bsg_credit_rr_sched.sv - directed and randomized checks against a behavioural scheduler model
module tb_bsg_credit_rr_sched;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk;
  logic         reset_i;
  logic [N-1:0] req_i;
  logic [N-1:0] last_i;
  logic         credits_avail_i;
  logic [N-1:0] grant_o;
  logic [1:0]   tag_o;
  logic         valid_o;
  logic         dec_credit_o;
  logic         ready_o;
  logic         locked_o;
  logic         starve_o;

  int total;
  int bad;

  // Model: cycles since reset release (saturating at W), packet owner (-1 = none), pointer, last tag.
  int since_rst;
  int m_owner;
  int m_ptr;
  int m_tag;

  bsg_credit_rr_sched #(
    .num_req_p         (N),
    .init_wait_cycles_p(W)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .req_i          (req_i),
    .last_i         (last_i),
    .credits_avail_i(credits_avail_i),
    .grant_o        (grant_o),
    .tag_o          (tag_o),
    .valid_o        (valid_o),
    .dec_credit_o   (dec_credit_o),
    .ready_o        (ready_o),
    .locked_o       (locked_o),
    .starve_o       (starve_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cycle(input bit chk, input logic [N-1:0] want);
    logic [N-1:0] eg;
    int           gi;
    int           idx;
    bit           rdy;
    bit           elig;
    @(negedge clk);
    rdy  = (since_rst >= W);
    eg   = '0;
    gi   = -1;
    elig = 1'b0;
    if (rdy) begin
      if (m_owner >= 0) begin
        elig = req_i[m_owner];
        if (elig && credits_avail_i) gi = m_owner;
      end else begin
        elig = |req_i;
        if (credits_avail_i) begin
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (gi < 0 && req_i[idx]) gi = idx;
          end
        end
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;

    check("grant",  32'(grant_o),      32'(eg));
    check("valid",  32'(valid_o),      32'(gi >= 0));
    check("dec",    32'(dec_credit_o), 32'(gi >= 0));
    check("tag",    32'(tag_o),        32'((gi >= 0) ? gi : m_tag));
    check("ready",  32'(ready_o),      32'(rdy));
    check("locked", 32'(locked_o),     32'(m_owner >= 0));
    check("starve", 32'(starve_o),     32'(rdy && elig && !credits_avail_i));
    if (chk) check("plan_grant", 32'(grant_o), 32'(want));

    if (reset_i) begin
      since_rst = 0;
      m_owner   = -1;
      m_ptr     = 0;
      m_tag     = 0;
    end else begin
      if (since_rst < W) since_rst++;
      if (gi >= 0) begin
        m_tag = gi;
        if (last_i[gi]) begin
          m_owner = -1;
          m_ptr   = (gi + 1) % N;
        end else begin
          m_owner = gi;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset_i         = 1'b1;
    req_i           = '0;
    last_i          = '0;
    credits_avail_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    since_rst = 0;
    m_owner   = -1;
    m_ptr     = 0;
    m_tag     = 0;

    // Init hold-off, then round-robin of single-beat packets
    req_i           = 4'b1111;
    last_i          = 4'b1111;
    credits_avail_i = 1'b1;
    cycle(1'b0, 4'b0000);
    reset_i = 1'b0;
    for (int i = 0; i < W; i++) cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0001);
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b0001);

    // Packet lock: requester 2 sends three beats while requester 0 waits
    req_i  = 4'b0101;
    last_i = 4'b0001;
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0100);
    last_i = 4'b0101;
    cycle(1'b1, 4'b0100);
    req_i  = 4'b0001;
    last_i = 4'b0001;
    cycle(1'b1, 4'b0001);

    // Credit starvation while requester 1 owns the channel
    req_i  = 4'b0010;
    last_i = 4'b0000;
    cycle(1'b1, 4'b0010);
    req_i           = 4'b0011;
    credits_avail_i = 1'b0;
    repeat (5) cycle(1'b1, 4'b0000);
    credits_avail_i = 1'b1;
    cycle(1'b1, 4'b0010);
    last_i = 4'b0010;
    cycle(1'b1, 4'b0010);

    // Owner stall: requester 3 owns, drops its request while requester 1 asks
    req_i  = 4'b1000;
    last_i = 4'b0000;
    cycle(1'b1, 4'b1000);
    req_i = 4'b0010;
    repeat (3) cycle(1'b1, 4'b0000);
    req_i = 4'b1000;
    cycle(1'b1, 4'b1000);

    // Reset mid-packet, then fresh init with requester 0 winning first
    reset_i = 1'b1;
    req_i   = 4'b1111;
    cycle(1'b1, 4'b1000);
    reset_i = 1'b0;
    req_i   = 4'b0001;
    last_i  = 4'b0001;
    for (int i = 0; i < W; i++) cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0001);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      reset_i         = ($urandom_range(0, 99) == 0);
      req_i           = N'($urandom);
      last_i          = N'($urandom);
      credits_avail_i = ($urandom_range(0, 3) != 0);
      cycle(1'b0, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_credit_rr_sched.md
# bsg_credit_rr_sched

Credit-gated round-robin packet scheduler that shares one credit-flow-controlled outbound channel among `num_req_p` requesters. It sits in the spend-credits clock domain beside the async credit counter. It consumes the counter's credits-available flag and pulses the counter's decrement input once per transmitted beat. Multi-beat packets are never interleaved: a requester that starts a packet keeps the channel until its last beat. After reset, grants are held off for a programmable number of cycles so the counter's synchronizers can settle.

## Interface
Parameters:
- `num_req_p`, default 4: number of requesters; must be ≥ 2.
- `init_wait_cycles_p`, default 4: cycles after reset release before any grant; must be ≥ 1.
- `lg_req_lp`, derived: `$clog2(num_req_p)`.

Ports:
- `clk_i` — in, 1 — single clock; this is the counter's spend-credits clock.
- `reset_i` — in, 1 — synchronous, active-high reset.
- `req_i` — in, `num_req_p` — per-requester beat valid.
- `last_i` — in, `num_req_p` — per-requester flag marking the current beat as the last of its packet.
- `credits_avail_i` — in, 1 — from the counter's credits-available output.
- `grant_o` — out, `num_req_p` — one-hot or zero; a beat of requester i transfers in the cycle `grant_o[i]` is high.
- `tag_o` — out, `lg_req_lp` — index of the granted requester; holds its last value when no grant is issued.
- `valid_o` — out, 1 — equals `|grant_o`.
- `dec_credit_o` — out, 1 — equals `valid_o`; drives the counter's decrement input.
- `ready_o` — out, 1 — init wait complete.
- `locked_o` — out, 1 — a packet is in progress and the channel is owned.
- `starve_o` — out, 1 — high when `ready_o` is high, a request is eligible, and `credits_avail_i` is 0.

## Operation
- FSM states:
  - INIT: `ready_o` = 0; wait counter increments every cycle.
  - IDLE: arbitrate among requesters.
  - LOCK: one owner holds the channel.
- Reset puts the FSM in INIT and clears the wait counter, the priority pointer `ptr_r` and the owner register. Reset asserted in any state, including mid-packet, aborts the packet. No credit is returned.
- INIT → IDLE after the cycle in which the wait counter equals `init_wait_cycles_p`−1. No grants are issued in INIT, regardless of `req_i`.
- IDLE:
  - If `credits_avail_i` = 1 and `req_i` ≠ 0, grant the first set bit scanning cyclically from `ptr_r` upward.
  - Winner's `last_i` = 1: stay in IDLE and set `ptr_r` ← winner+1 (mod `num_req_p`).
  - Winner's `last_i` = 0: go to LOCK with owner ← winner. `ptr_r` is unchanged.
- LOCK:
  - Grant only the owner, and only when `req_i[owner]` and `credits_avail_i` are both 1.
  - Other requests are ignored.
  - If the owner drops `req_i`, hold LOCK and stall indefinitely.
  - A granted beat with `last_i[owner]` = 1 returns the FSM to IDLE with `ptr_r` ← owner+1.
- At most one grant, and therefore one credit, per cycle.
- `last_i` is sampled only for the granted requester.
- `starve_o`: eligible means any `req_i` in IDLE, or `req_i[owner]` in LOCK.

## Timing
- `grant_o`, `tag_o`, `valid_o`, `dec_credit_o` and `starve_o` are combinational from current state, `req_i`, `last_i` and `credits_avail_i`. A grant is issued in the same cycle as the request, with no registered latency.
- `credits_avail_i` is trusted combinationally each cycle. The counter registers the decrement at the same edge, so back-to-back grants are legal while the flag stays high.
- State, `ptr_r`, owner and `tag_o` update on the rising edge of `clk_i`.
- Reset values: `grant_o` = 0, `valid_o` = 0, `dec_credit_o` = 0, `ready_o` = 0, `locked_o` = 0, `starve_o` = 0, `tag_o` = 0.
- `ready_o` is registered and first goes high in cycle `init_wait_cycles_p`, where cycle 0 is the first cycle with `reset_i` low.
- `locked_o` is registered: high in the cycles after a non-last grant, low from the cycle after the last beat.
- `ptr_r` wraps from `num_req_p`−1 to 0.

## Test plan
- **Init hold-off.** Reset for 3 cycles, then `req_i` = 4'b1111 and `credits_avail_i` = 1 held. Expect no grant in cycles 0–3, `ready_o` rising in cycle 4, and `grant_o` = 4'b0001 in cycle 4.
- **Round-robin.** After init, all four requesters send single-beat packets (`last_i` = 1) with credits held high. Expect grants 0,1,2,3,0 in consecutive cycles and `dec_credit_o` high in each of those cycles.
- **Packet lock.** Requester 2 sends a 3-beat packet while requester 0 is also requesting. Expect `grant_o` = 4'b0100 for three cycles and `locked_o` high in the following two. Requester 0 is granted in the cycle after the last beat, `ptr_r` having become 3.
- **Credit starvation.** In LOCK, drop `credits_avail_i` for 5 cycles. Expect zero grants, `starve_o` = 1 and ownership retained. On restore, the owner is granted in the same cycle.
- **Owner stall.** In LOCK, the owner drops `req_i` for 3 cycles while requester 1 requests. Expect no grant to requester 1 and `starve_o` = 0.
- **Reset mid-packet.** Assert reset during LOCK. Expect all outputs at reset values in the next cycle, INIT re-entered, and the first grant after init coming from requester 0 if it is requesting.
